// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer
//
// Runs one external, purely combinational AES engine in counter (CTR) mode.
// A session opens on a start pulse that loads the key and the initial counter
// block. After that, each input block is XORed with AES(key, counter) and
// presented on the output stream. The counter then advances. Encryption and
// decryption are the same operation.
//
// The engine's combinational path is treated as a multicycle path. The engine
// is driven only from registers (key_q, ctr_q). Its output is sampled once,
// on the last of ENGINE_WAIT compute cycles.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   start            one-cycle pulse, loads key_in / iv_in and opens a session
//   key_in, iv_in    session key and initial counter block
//   busy             session open (state other than idle)
//   in_valid/ready   input block handshake; in_data, in_last
//   out_valid/ready  result handshake; out_data, out_last
//   eng_in, eng_key  to the engine (counter and key registers)
//   eng_out          from the engine
//   ctr_wrap         sticky: low CTR_W counter bits wrapped in this session
module aes_ctr_sequencer #(
    parameter int unsigned N           = 128,
    parameter int unsigned CTR_W       = 32,
    parameter int unsigned ENGINE_WAIT = 2
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           start,
    input  logic [N-1:0]   key_in,
    input  logic [127:0]   iv_in,
    output logic           busy,

    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    input  logic           in_last,

    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           out_last,

    output logic [127:0]   eng_in,
    output logic [N-1:0]   eng_key,
    input  logic [127:0]   eng_out,

    output logic           ctr_wrap
);

    // Elaboration-time parameter sanity.
    if (N != 128 && N != 192 && N != 256) begin : g_bad_n
        $error("aes_ctr_sequencer: N must be 128, 192 or 256");
    end
    if (CTR_W < 1 || CTR_W > 128) begin : g_bad_ctr_w
        $error("aes_ctr_sequencer: CTR_W must be in 1..128");
    end
    if (ENGINE_WAIT < 1) begin : g_bad_wait
        $error("aes_ctr_sequencer: ENGINE_WAIT must be >= 1");
    end

    localparam int unsigned WaitW = (ENGINE_WAIT > 1) ? $clog2(ENGINE_WAIT) : 1;
    localparam logic [WaitW-1:0] WaitInit = WaitW'(ENGINE_WAIT - 1);

    // Selects the incrementing low CTR_W bits of the counter block. A mask
    // avoids a zero-width upper slice when CTR_W == 128.
    localparam logic [127:0] CtrMask = {128{1'b1}} >> (128 - CTR_W);

    typedef enum logic [1:0] {
        StIdle,
        StReady,
        StCompute,
        StOutput
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     key_q, key_d;
    logic [127:0]     ctr_q, ctr_d;
    logic [127:0]     data_q, data_d;
    logic             last_q, last_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [127:0]     out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             wrap_q, wrap_d;

    logic [127:0]     ctr_inc;
    logic             ctr_at_max;

    // Low bits advance modulo 2^CTR_W. No carry reaches the upper bits.
    assign ctr_inc    = (ctr_q & ~CtrMask) | ((ctr_q + 128'd1) & CtrMask);
    assign ctr_at_max = (ctr_q & CtrMask) == CtrMask;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        data_d     = data_q;
        last_d     = last_q;
        wait_d     = wait_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        wrap_d     = wrap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    ctr_d   = iv_in;
                    wrap_d  = 1'b0;
                    state_d = StReady;
                end
            end

            StReady: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    wait_d  = WaitInit;
                    state_d = StCompute;
                end
            end

            StCompute: begin
                if (wait_q == '0) begin
                    // Engine output has settled; this is its only sample point.
                    out_data_d = eng_out ^ data_q;
                    out_last_d = last_q;
                    ctr_d      = ctr_inc;
                    if (ctr_at_max) begin
                        wrap_d = 1'b1;
                    end
                    state_d    = StOutput;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            StOutput: begin
                if (out_ready) begin
                    state_d = out_last_q ? StIdle : StReady;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            key_q      <= '0;
            ctr_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            wait_q     <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ctr_q      <= ctr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            wrap_q     <= wrap_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StReady);
    assign out_valid = (state_q == StOutput);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign eng_in    = ctr_q;
    assign eng_key   = key_q;
    assign ctr_wrap  = wrap_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Bench for aes_ctr_sequencer (N=128, CTR_W=32, ENGINE_WAIT=2).
// Stands in for the AES engine. For the SP800-38A key and counters it
// returns the published keystream. For every other key and counter it
// returns a deterministic mixing function.
module tb_aes_ctr_sequencer;

    localparam int unsigned N = 128;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV1P = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] KS1 = C1 ^ P1;
    localparam logic [127:0] KS2 = C2 ^ P2;

    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV2 = 128'h00112233445566778899aabbffffffff;
    localparam logic [127:0] IV2W = 128'h00112233445566778899aabb00000000;
    localparam logic [127:0] K3  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] IV3 = 128'h0f0e0d0c0b0a09080706050400000010;
    localparam logic [127:0] K4  = 128'h55aa55aa00ff00ff1234567887654321;
    localparam logic [127:0] IV4 = 128'hcafef00d0000000011111111fffffff0;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   key_in;
    logic [127:0]   iv_in;
    logic           busy;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           out_last;
    logic [127:0]   eng_in;
    logic [N-1:0]   eng_key;
    logic [127:0]   eng_out;
    logic           ctr_wrap;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mdl_key;
    logic [127:0] mdl_ctr;
    int           n_pass = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] eng_model(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] x;
        if (k == K1 && c == IV1) return KS1;
        if (k == K1 && c == IV1P) return KS2;
        x = c ^ {k[63:0], k[127:64]};
        x = x ^ {x[100:0], x[127:101]};
        x = x + 128'h9e3779b97f4a7c15f39cc0605cedc834;
        x = x ^ {x[60:0], x[127:61]};
        return x;
    endfunction

    assign eng_out = eng_model(eng_key, eng_in);

    aes_ctr_sequencer #(
        .N           (N),
        .CTR_W       (32),
        .ENGINE_WAIT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .iv_in     (iv_in),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .eng_in    (eng_in),
        .eng_key   (eng_key),
        .eng_out   (eng_out),
        .ctr_wrap  (ctr_wrap)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_eng_in"}, eng_in, 0);
        chk({tag, "_eng_key"}, eng_key, 0);
        chk({tag, "_ctr_wrap"}, ctr_wrap, 0);
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic do_start(input logic [127:0] k, input logic [127:0] iv);
        start  = 1'b1;
        key_in = k;
        iv_in  = iv;
        @(negedge clk);
        start   = 1'b0;
        mdl_key = k;
        mdl_ctr = iv;
    endtask

    task automatic put_block(input logic [127:0] d, input logic l, input logic [127:0] exp);
        int c = 0;
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sb.push_back('{data: exp, last: l});
        mdl_ctr = {mdl_ctr[127:32], mdl_ctr[31:0] + 32'd1};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put_auto(input logic [127:0] d, input logic l);
        put_block(d, l, d ^ eng_model(mdl_key, mdl_ctr));
    endtask

    // Called at the falling edge of the first cycle after the input handshake.
    task automatic wait_out(input string tag);
        int c = 1;
        while (!out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, c, 3);
    endtask

    task automatic take_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            e = '0;
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, e.data);
        chk({tag, "_last"}, out_last, e.last);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic get_block(input string tag);
        wait_out(tag);
        take_out(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        iv_in     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        mdl_key   = '0;
        mdl_ctr   = '0;
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // SP800-38A CTR-AES128, two blocks.
        do_start(K1, IV1);
        chk("sp_busy", busy, 1);
        chk("sp_in_ready", in_ready, 1);
        chk("sp_eng_key", eng_key, K1);
        chk("sp_eng_in", eng_in, IV1);
        put_block(P1, 1'b0, C1);
        get_block("sp_b1");
        put_block(P2, 1'b1, C2);
        get_block("sp_b2");
        chk("sp_end_busy", busy, 0);
        chk("sp_end_in_ready", in_ready, 0);
        chk("sp_end_out_valid", out_valid, 0);

        // Decryption is the same operation.
        do_start(K1, IV1);
        put_block(C1, 1'b1, P1);
        get_block("dec");
        chk("dec_end_busy", busy, 0);

        // Backpressure: result held, no new input, counter frozen.
        do_start(K1, IV1);
        put_block(P1, 1'b0, C1);
        wait_out("bp");
        in_valid = 1'b1;
        in_data  = P2;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_data", out_data, C1);
            chk("bp_eng_in", eng_in, IV1P);
            @(negedge clk);
        end
        take_out("bp_rel");
        chk("bp_after_out_valid", out_valid, 0);
        chk("bp_after_in_ready", in_ready, 1);
        put_block(P2, 1'b1, C2);
        get_block("bp_b2");
        chk("bp_end_busy", busy, 0);

        // Counter wrap in the low 32 bits.
        do_start(K2, IV2);
        put_auto(128'h0123456789abcdef0011223344556677, 1'b0);
        get_block("wrap_b1");
        chk("wrap_eng_in", eng_in, IV2W);
        chk("wrap_flag", ctr_wrap, 1);
        put_auto(128'hffeeddccbbaa99887766554433221100, 1'b1);
        get_block("wrap_b2");
        chk("wrap_sticky", ctr_wrap, 1);
        do_start(K3, IV3);
        chk("wrap_cleared", ctr_wrap, 0);

        // Reset while computing, then a fresh session.
        put_auto(128'h13579bdf2468ace0fdb97531eca86420, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("rst_mid");
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        do_start(K4, IV4);
        put_auto(128'h00000000000000000000000000000001, 1'b1);
        get_block("post_rst");
        chk("post_rst_busy", busy, 0);

        // start while busy is ignored.
        do_start(K1, IV1);
        start  = 1'b1;
        key_in = K2;
        iv_in  = IV2;
        @(negedge clk);
        start = 1'b0;
        chk("sb_eng_key", eng_key, K1);
        chk("sb_eng_in", eng_in, IV1);
        put_block(P1, 1'b0, C1);
        get_block("sb_b1");
        put_block(P2, 1'b1, C2);
        get_block("sb_b2");
        chk("sb_end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
